// File: rtl/mmc1_write_decoder_if.sv
// CPU cartridge-bus write port and MMC1 register outputs, grouped for mmc1_write_decoder.
// The CPU/bench side uses the master modport and the decoder uses the slave modport.
interface mmc1_write_decoder_if;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_rw;
  logic        cpu_rom_sel_n;
  logic        cpu_m2;
  logic [4:0]  ctrl;
  logic [4:0]  chr0;
  logic [4:0]  chr1;
  logic [4:0]  prg;
  logic [1:0]  mirroring;
  logic [3:0]  prg_bank;
  logic        reg_wr_stb;

  modport master (
    output cpu_addr, cpu_data_in, cpu_rw, cpu_rom_sel_n, cpu_m2,
    input  ctrl, chr0, chr1, prg, mirroring, prg_bank, reg_wr_stb
  );

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_rw, cpu_rom_sel_n, cpu_m2,
    output ctrl, chr0, chr1, prg, mirroring, prg_bank, reg_wr_stb
  );
endinterface

// File: rtl/mmc1_write_decoder.sv
// MMC1 serial-load register file fed by 6502 writes to $8000-$FFFF, plus PRG bank select.
// Optional feature: define MMC1_CONSEC_IGNORE_EN to drop serial writes on back-to-back ROM write cycles.
module mmc1_write_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  mmc1_write_decoder_if.slave bus
);

  logic [SYNC_STAGES-1:0] r_m2Sync;
  logic [SYNC_STAGES-1:0] r_rwSync;
  logic [SYNC_STAGES-1:0] r_romSync;
  logic                   r_m2Prev;

  logic [1:0] r_latA;
  logic       r_latD7;
  logic       r_latD0;
  logic       r_latRw;
  logic       r_latRom;

  logic [4:0] r_shift;
  logic [4:0] r_ctrl;
  logic [4:0] r_chr0;
  logic [4:0] r_chr1;
  logic [4:0] r_prg;
  logic       r_regWrStb;
  logic [3:0] r_prgBank;

  logic       w_m2;
  logic       w_rw;
  logic       w_rom;
  logic       w_m2Fall;
  logic       w_isWrite;
  logic       w_ignore;
  logic [4:0] w_value;

  assign w_m2      = r_m2Sync[SYNC_STAGES-1];
  assign w_rw      = r_rwSync[SYNC_STAGES-1];
  assign w_rom     = r_romSync[SYNC_STAGES-1];
  assign w_m2Fall  = r_m2Prev & ~w_m2;
  assign w_isWrite = ~r_latRw & ~r_latRom;
  assign w_value   = {r_latD0, r_shift[4:1]};

  // Idle values (m2 low, read, ROM deselected) keep reset from looking like a bus cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m2Sync  <= '0;
      r_rwSync  <= '1;
      r_romSync <= '1;
      r_m2Prev  <= 1'b0;
    end else begin
      r_m2Sync  <= {r_m2Sync[SYNC_STAGES-2:0], bus.cpu_m2};
      r_rwSync  <= {r_rwSync[SYNC_STAGES-2:0], bus.cpu_rw};
      r_romSync <= {r_romSync[SYNC_STAGES-2:0], bus.cpu_rom_sel_n};
      r_m2Prev  <= w_m2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latA   <= 2'b00;
      r_latD7  <= 1'b0;
      r_latD0  <= 1'b0;
      r_latRw  <= 1'b1;
      r_latRom <= 1'b1;
    end else if (w_m2) begin
      r_latA   <= bus.cpu_addr[14:13];
      r_latD7  <= bus.cpu_data_in[7];
      r_latD0  <= bus.cpu_data_in[0];
      r_latRw  <= w_rw;
      r_latRom <= w_rom;
    end
  end

`ifdef MMC1_CONSEC_IGNORE_EN
  logic r_lastRomWr;

  // Any M2 cycle that is not a ROM write breaks the back-to-back chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastRomWr <= 1'b0;
    end else if (w_m2Fall) begin
      r_lastRomWr <= w_isWrite;
    end
  end

  assign w_ignore = r_lastRomWr;
`else
  assign w_ignore = 1'b0;
`endif

  // The marker bit reaching shift[0] means the current write supplies the fifth bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= 5'b10000;
      r_ctrl     <= 5'h0C;
      r_chr0     <= 5'h00;
      r_chr1     <= 5'h00;
      r_prg      <= 5'h00;
      r_regWrStb <= 1'b0;
    end else begin
      r_regWrStb <= 1'b0;
      if (w_m2Fall && w_isWrite) begin
        if (r_latD7) begin
          r_shift <= 5'b10000;
          r_ctrl  <= r_ctrl | 5'h0C;
        end else if (!w_ignore) begin
          if (!r_shift[0]) begin
            r_shift <= w_value;
          end else begin
            r_shift    <= 5'b10000;
            r_regWrStb <= 1'b1;
            case (r_latA)
              2'b00:   r_ctrl <= w_value;
              2'b01:   r_chr0 <= w_value;
              2'b10:   r_chr1 <= w_value;
              default: r_prg  <= w_value;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prgBank <= 4'h0;
    end else begin
      case (r_ctrl[3:2])
        2'b10:   r_prgBank <= bus.cpu_addr[14] ? r_prg[3:0] : 4'h0;
        2'b11:   r_prgBank <= bus.cpu_addr[14] ? 4'hF : r_prg[3:0];
        default: r_prgBank <= {r_prg[3:1], bus.cpu_addr[14]};
      endcase
    end
  end

  assign bus.ctrl       = r_ctrl;
  assign bus.chr0       = r_chr0;
  assign bus.chr1       = r_chr1;
  assign bus.prg        = r_prg;
  assign bus.mirroring  = r_ctrl[1:0];
  assign bus.prg_bank   = r_prgBank;
  assign bus.reg_wr_stb = r_regWrStb;

endmodule
